// File: rtl/sdram_width_bridge_pkg.sv
// Shared SDRAM user-port parameters and the width-bridge FSM state type.
package SDRAM_params;

  localparam int USER_ADDRESS_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/sdram_width_bridge.sv
// Splits CPU_WIDTH accesses into little-endian SDRAM_WIDTH beats and reassembles reads.
// Optional response watchdog enabled by defining SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_width_bridge
  import SDRAM_params::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int SDRAM_WIDTH    = 16,
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          re_CPU,
  input  logic                          we_CPU,
  input  logic [CPU_ADDR_WIDTH-1:0]     addr_CPU,
  input  logic [CPU_WIDTH-1:0]          data_write_CPU,
  output logic [CPU_WIDTH-1:0]          data_read_CPU,
  output logic                          valid_CPU,
  output logic                          busy_CPU,
  output logic                          err_CPU,
  output logic [USER_ADDRESS_WIDTH-1:0] addr_SDRAM,
  output logic                          re_SDRAM,
  output logic                          we_SDRAM,
  output logic [SDRAM_WIDTH-1:0]        data_write_SDRAM,
  input  logic [SDRAM_WIDTH-1:0]        data_read_SDRAM,
  input  logic                          valid_SDRAM,
  input  logic                          done_SDRAM
);

  localparam int BEATS      = CPU_WIDTH / SDRAM_WIDTH;
  localparam int BYTE_SHIFT = $clog2(SDRAM_WIDTH / 8);
  localparam int BEAT_BITS  = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam int AW_EXT     = (CPU_ADDR_WIDTH > USER_ADDRESS_WIDTH) ? CPU_ADDR_WIDTH
                                                                    : USER_ADDRESS_WIDTH;

  // First beat address of the CPU word containing the byte address.
  function automatic logic [USER_ADDRESS_WIDTH-1:0] beat_base(
    input logic [CPU_ADDR_WIDTH-1:0] a
  );
    logic [AW_EXT-1:0] w;
    w = AW_EXT'(a) >> BYTE_SHIFT;
    w[BEAT_BITS-1:0] = '0;
    return w[USER_ADDRESS_WIDTH-1:0];
  endfunction

  bridge_state_t                 state_p0;
  logic [BEAT_BITS-1:0]          beat_p0;
  logic [BEAT_BITS-1:0]          beat_inc;
  logic                          op_wr_p0;
  logic [USER_ADDRESS_WIDTH-1:0] base_p0;
  logic [CPU_WIDTH-1:0]          wr_data_p0;
  logic [CPU_WIDTH-1:0]          rd_asm_p0;
  logic [CPU_WIDTH-1:0]          rd_merge;
  logic                          beat_resp;
  logic                          last_beat;

  assign beat_inc  = beat_p0 + 1'b1;
  assign beat_resp = op_wr_p0 ? done_SDRAM : valid_SDRAM;
  assign last_beat = (beat_p0 == BEAT_BITS'(BEATS - 1));

  always_comb begin
    rd_merge = rd_asm_p0;
    rd_merge[int'(beat_p0)*SDRAM_WIDTH +: SDRAM_WIDTH] = data_read_SDRAM;
  end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_cnt_p0;
  logic            err_p0;

  assign err_CPU = err_p0;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

  assign err_CPU = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0         <= IDLE;
      beat_p0          <= '0;
      op_wr_p0         <= 1'b0;
      base_p0          <= '0;
      wr_data_p0       <= '0;
      rd_asm_p0        <= '0;
      data_read_CPU    <= '0;
      valid_CPU        <= 1'b0;
      busy_CPU         <= 1'b0;
      addr_SDRAM       <= '0;
      re_SDRAM         <= 1'b0;
      we_SDRAM         <= 1'b0;
      data_write_SDRAM <= '0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      wd_cnt_p0        <= '0;
      err_p0           <= 1'b0;
`endif
    end else begin
      re_SDRAM  <= 1'b0;
      we_SDRAM  <= 1'b0;
      valid_CPU <= 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      err_p0    <= 1'b0;
`endif
      case (state_p0)
        IDLE: begin
          // Write wins when both requests arrive together.
          if (we_CPU || re_CPU) begin
            op_wr_p0         <= we_CPU;
            base_p0          <= beat_base(addr_CPU);
            wr_data_p0       <= data_write_CPU;
            beat_p0          <= '0;
            addr_SDRAM       <= beat_base(addr_CPU);
            data_write_SDRAM <= data_write_CPU[SDRAM_WIDTH-1:0];
            we_SDRAM         <= we_CPU;
            re_SDRAM         <= ~we_CPU;
            busy_CPU         <= 1'b1;
            state_p0         <= ISSUE;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
            wd_cnt_p0        <= '0;
`endif
          end
        end
        ISSUE: begin
          state_p0 <= WAIT;
        end
        WAIT: begin
          if (beat_resp) begin
            if (!op_wr_p0) rd_asm_p0 <= rd_merge;
            if (last_beat) begin
              if (!op_wr_p0) data_read_CPU <= rd_merge;
              valid_CPU <= 1'b1;
              busy_CPU  <= 1'b0;
              state_p0  <= IDLE;
            end else begin
              beat_p0          <= beat_inc;
              addr_SDRAM       <= base_p0 + USER_ADDRESS_WIDTH'(beat_inc);
              data_write_SDRAM <= wr_data_p0[int'(beat_inc)*SDRAM_WIDTH +: SDRAM_WIDTH];
              we_SDRAM         <= op_wr_p0;
              re_SDRAM         <= ~op_wr_p0;
              state_p0         <= ISSUE;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
              wd_cnt_p0        <= '0;
`endif
            end
          end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
          // Abort after TIMEOUT_CYCLES silent WAIT cycles; aborted reads return zero.
          else if (wd_cnt_p0 == TO_W'(TIMEOUT_CYCLES - 1)) begin
            if (!op_wr_p0) data_read_CPU <= '0;
            valid_CPU <= 1'b1;
            err_p0    <= 1'b1;
            busy_CPU  <= 1'b0;
            state_p0  <= IDLE;
          end else begin
            wd_cnt_p0 <= wd_cnt_p0 + 1'b1;
          end
`endif
        end
        default: begin
          state_p0 <= IDLE;
          busy_CPU <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_width_bridge.sv
// Directed bench for sdram_width_bridge: 32-bit table vectors plus 64-bit, reset and timeout sequences.
module tb_sdram_width_bridge;
  import SDRAM_params::*;

  localparam int AW = USER_ADDRESS_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic          re = 0, we = 0;
  logic [31:0]   addr = 0, wdata = 0;
  logic [31:0]   rdata;
  logic          valid, busy, err;
  logic [AW-1:0] addr_sd;
  logic          re_sd, we_sd;
  logic [15:0]   wd_sd;
  logic [15:0]   rd_sd = 0;
  logic          vld_sd = 0, done_sd = 0;

  logic          re64 = 0, we64 = 0;
  logic [31:0]   addr64 = 0;
  logic [63:0]   wdata64 = 0;
  logic [63:0]   rdata64;
  logic          valid64, busy64, err64;
  logic [AW-1:0] addr_sd64;
  logic          re_sd64, we_sd64;
  logic [15:0]   wd_sd64;
  logic [15:0]   rd_sd64 = 0;
  logic          vld_sd64 = 0, done_sd64 = 0;

  sdram_width_bridge #(.CPU_WIDTH(32), .SDRAM_WIDTH(16), .CPU_ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .re_CPU(re), .we_CPU(we), .addr_CPU(addr),
    .data_write_CPU(wdata), .data_read_CPU(rdata), .valid_CPU(valid), .busy_CPU(busy),
    .err_CPU(err), .addr_SDRAM(addr_sd), .re_SDRAM(re_sd), .we_SDRAM(we_sd),
    .data_write_SDRAM(wd_sd), .data_read_SDRAM(rd_sd), .valid_SDRAM(vld_sd), .done_SDRAM(done_sd)
  );

  sdram_width_bridge #(.CPU_WIDTH(64), .SDRAM_WIDTH(16), .CPU_ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .re_CPU(re64), .we_CPU(we64), .addr_CPU(addr64),
    .data_write_CPU(wdata64), .data_read_CPU(rdata64), .valid_CPU(valid64), .busy_CPU(busy64),
    .err_CPU(err64), .addr_SDRAM(addr_sd64), .re_SDRAM(re_sd64), .we_SDRAM(we_sd64),
    .data_write_SDRAM(wd_sd64), .data_read_SDRAM(rd_sd64), .valid_SDRAM(vld_sd64), .done_SDRAM(done_sd64)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            wr;
    bit            both;
    bit            busyreq;
    bit            stray;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [15:0]   rb0, rb1;
    int            lat;
    logic [AW-1:0] ea0, ea1;
    logic [15:0]   ew0, ew1;
    logic [31:0]   exp_rd;
  } vec_t;

  // One 32-bit transaction against a controller answering lat cycles after each strobe.
  task automatic run_vec(input vec_t v);
    int k;
    int ns;
    bit found;
    @(negedge clk);
    we = v.wr; re = !v.wr || v.both; addr = v.addr; wdata = v.wdata; k = 0;
    for (int b = 0; b < 2; b++) begin
      found = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); k++;
        re = 0; we = 0; vld_sd = 0; done_sd = 0;
        if (re_sd || we_sd) begin found = 1; break; end
      end
      check("strobe_seen", found, 1);
      check("strobe_cycle", k, (b == 0) ? 1 : 2 + v.lat);
      check("strobe_we", we_sd, v.wr);
      check("strobe_re", re_sd, !v.wr);
      check("beat_addr", addr_sd, (b == 0) ? v.ea0 : v.ea1);
      if (v.wr) check("beat_wdata", wd_sd, (b == 0) ? v.ew0 : v.ew1);
      check("busy_in_flight", busy, 1);
      if (b == 0 && v.busyreq) begin re = 1; we = 1; addr = 32'h100; wdata = 32'hFFFF_FFFF; end
      for (int j = 0; j < v.lat; j++) begin
        @(negedge clk); k++;
        re = 0; we = 0; vld_sd = 0;
        if (v.stray && j == v.lat - 2) begin vld_sd = 1; rd_sd = 16'hAAAA; end
      end
      if (v.wr) done_sd = 1;
      else begin vld_sd = 1; rd_sd = (b == 0) ? v.rb0 : v.rb1; end
    end
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); k++;
      vld_sd = 0; done_sd = 0;
      if (valid) begin found = 1; break; end
    end
    check("valid_seen", found, 1);
    check("valid_cycle", k, 3 + 2 * v.lat);
    check("err_on_ok", err, 0);
    check("busy_at_valid", busy, 0);
    check("data_read", rdata, v.exp_rd);
    @(negedge clk);
    check("valid_one_cycle", valid, 0);
    ns = 0;
    repeat (5) begin
      @(negedge clk);
      if (re_sd || we_sd || valid) ns++;
    end
    check("no_extra_activity", ns, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int k;
    bit found;
    int ns;
    logic [15:0] b64[4];

    vecs[0] = '{1, 0, 0, 0, 32'h0000_0000, 32'h1234_5678, 16'h0, 16'h0, 2,
                24'h000000, 24'h000001, 16'h5678, 16'h1234, 32'h0000_0000};
    vecs[1] = '{0, 0, 0, 0, 32'h0000_0008, 32'h0, 16'h5678, 16'h1234, 2,
                24'h000004, 24'h000005, 16'h0, 16'h0, 32'h1234_5678};
    vecs[2] = '{1, 0, 0, 1, 32'h0000_0008, 32'hCAFE_BABE, 16'h0, 16'h0, 2,
                24'h000004, 24'h000005, 16'hBABE, 16'hCAFE, 32'h1234_5678};
    vecs[3] = '{0, 0, 0, 0, 32'h0000_0006, 32'h0, 16'hBEEF, 16'hDEAD, 1,
                24'h000002, 24'h000003, 16'h0, 16'h0, 32'hDEAD_BEEF};
    vecs[4] = '{0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 16'h0001, 16'h8000, 3,
                24'hFFFFFE, 24'hFFFFFF, 16'h0, 16'h0, 32'h8000_0001};
    vecs[5] = '{1, 1, 1, 0, 32'h0000_0012, 32'h00FF_FF00, 16'h0, 16'h0, 1,
                24'h000008, 24'h000009, 16'hFF00, 16'h00FF, 32'h8000_0001};
    b64[0] = 16'h1111; b64[1] = 16'h2222; b64[2] = 16'h3333; b64[3] = 16'h4444;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_re_sd", re_sd, 0);
    check("rst_we_sd", we_sd, 0);
    check("rst_addr_sd", addr_sd, 0);
    check("rst_wd_sd", wd_sd, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 6; n++) run_vec(vecs[n]);

    // 64-bit read, zero-wait controller, misaligned address 0x6
    @(negedge clk);
    re64 = 1; addr64 = 32'h6; k = 0;
    for (int b = 0; b < 4; b++) begin
      found = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); k++;
        re64 = 0; vld_sd64 = 0;
        if (re_sd64 || we_sd64) begin found = 1; break; end
      end
      check("w64_strobe_seen", found, 1);
      check("w64_strobe_cycle", k, 1 + 2 * b);
      check("w64_beat_addr", addr_sd64, AW'(b));
      check("w64_strobe_re", re_sd64, 1);
      @(negedge clk); k++;
      vld_sd64 = 1; rd_sd64 = b64[b];
    end
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); k++;
      vld_sd64 = 0;
      if (valid64) begin found = 1; break; end
    end
    check("w64_valid_seen", found, 1);
    check("w64_valid_cycle", k, 9);
    check("w64_data", rdata64, 64'h4444_3333_2222_1111);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    // No response: abort after 16 WAIT cycles
    @(negedge clk);
    re = 1; addr = 32'h40; k = 0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); k++;
      re = 0;
      if (valid) begin found = 1; break; end
    end
    check("to_valid_seen", found, 1);
    check("to_valid_cycle", k, 18);
    check("to_err", err, 1);
    check("to_rdata_zero", rdata, 0);
    check("to_busy", busy, 0);
    @(negedge clk);
    check("to_err_one_cycle", err, 0);
`endif

    // Reset mid-read: first beat answered, second left hanging
    @(negedge clk);
    re = 1; addr = 32'h20; k = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); k++;
      re = 0;
      if (re_sd) begin found = 1; break; end
    end
    check("mr_strobe_seen", found, 1);
    check("mr_beat_addr", addr_sd, 24'h000010);
    @(negedge clk);
    vld_sd = 1; rd_sd = 16'h7777;
    @(negedge clk);
    vld_sd = 0;
    ns = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid) ns++;
    end
    check("mr_no_valid_while_hung", ns, 0);
    check("mr_busy_while_hung", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_rst_busy", busy, 0);
    check("mr_rst_valid", valid, 0);
    check("mr_rst_addr_sd", addr_sd, 0);
    check("mr_rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ns = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid || re_sd || we_sd || busy) ns++;
    end
    check("mr_quiet_after_reset", ns, 0);

    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
